ledge_mover: RTL and testbench
==============================

Name: ledge_mover

Overview:
- Produces position of one moving platform; drives ledgeX/ledgeY inputs of the ledge renderer, and ledge_dx to fighter physics so a standing fighter is carried.
- Moves ledge horizontally between two bounds, one step per video frame, with a dwell at each end.
- Sits between top-level frame_clk (vsync) and ledge renderer plus fighter collision logic.

Parameters:
- X_MIN, 10'd134, left turnaround centre X; must be >= LEDGE_HALF_W (67).
- X_MAX, 10'd506, right turnaround centre X; must be <= 639-67.
- X_START, 10'd320, centre X after reset; X_MIN <= X_START <= X_MAX.
- Y_HOME, 10'd300, centre Y (base when bob disabled).
- STEP, 10'd2, pixels moved per frame tick; 1..63.
- PAUSE_FRAMES, 8'd60, dwell ticks at each end; 0 = immediate reversal.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  vsync-rate frame signal, synchronous to Clk.
- enable  in  1  1 = motion runs; 0 = freeze.
- ledgeX  out  10  ledge centre X.
- ledgeY  out  10  ledge centre Y.
- ledge_dx  out  10  signed two's-complement X delta applied on last tick.
- moving_right  out  1  1 while in MOVE_R or PAUSE_R.

Behaviour:
- Reset (async, active-high): ledgeX=X_START, ledgeY=Y_HOME, ledge_dx=0, moving_right=1, state=MOVE_R, pause_cnt=0, frame_clk delay flop=0.
- Tick: one-Clk pulse when frame_clk is 1 and its delayed copy is 0. All outputs are registered and update on the Clk edge that ends the tick cycle. No updates occur between ticks.
- States: MOVE_R, PAUSE_R, MOVE_L, PAUSE_L.
- MOVE_R tick:
  - If ledgeX+STEP >= X_MAX: ledgeX=X_MAX, ledge_dx=X_MAX-old ledgeX (may be < STEP or 0), go PAUSE_R, pause_cnt=0.
  - Else ledgeX += STEP, ledge_dx = +STEP.
- MOVE_L: mirror. Clamp when ledgeX-STEP <= X_MIN, so no unsigned underflow. ledge_dx is negative.
- PAUSE_x tick: ledge_dx=0. If pause_cnt == PAUSE_FRAMES-1, go to the opposite MOVE state; else pause_cnt++. PAUSE_FRAMES=0 skips pause: the clamp tick goes straight to the opposite MOVE state.
- moving_right: 1 in MOVE_R/PAUSE_R, 0 in MOVE_L/PAUSE_L. Updates with the state.
- enable=0 at a tick: state, ledgeX, ledgeY and pause_cnt hold; ledge_dx=0. When enable returns, motion resumes from the held state.
- enable changing between ticks has no effect until the next tick.
- Reset mid-move or mid-pause: immediate return to reset values; the pause count is lost.
- ledge_dx is valid from the cycle after a tick until the next tick. Consumers sample it on the tick.

Optional Feature:
- LEDGE_BOB_EN defined: 3-bit bob_phase increments on each moving tick (not in pause or when frozen). ledgeY = Y_HOME + off, off = phase<4 ? phase : 8-phase (0,1,2,3,4,3,2,1). bob_phase resets to 0.
- Undefined: ledgeY constant Y_HOME; no bob logic is synthesized.

Decomposition:
- ledge_pkg:
  - state enum ledge_state_t {MOVE_R, PAUSE_R, MOVE_L, PAUSE_L}.
  - LEDGE_HALF_W=10'd67, LEDGE_HALF_H=10'd12, SCREEN_W=10'd640, SCREEN_H=10'd480.
- Sub-module frame_tick_gen (Clk, Reset, frame_clk -> tick) holds the edge detector and is reusable by fighter physics.

Test Plan:
- Reset with defaults, 93 ticks -> ledgeX steps 320,322,...,506; ledge_dx=+2 each tick; state PAUSE_R after tick 93.
- From PAUSE_R, 60 ticks -> ledgeX stays 506, ledge_dx=0; tick 61 -> ledgeX=504, ledge_dx=-2 (0x3FE), moving_right=0.
- STEP=4, X_START=320 -> tick 46 gives 504; tick 47 clamps to 506 with ledge_dx=+2.
- PAUSE_FRAMES=0, X_START=X_MAX-1, STEP=2 -> tick1: 506, dx=+1; tick2: 504, dx=-2.
- enable=0 for 10 ticks at ledgeX=400 in MOVE_L -> ledgeX 400, dx=0 throughout; re-enable -> next tick 398.
- Reset asserted asynchronously mid PAUSE_L (no Clk edge) -> outputs go to 320/300/0/1 immediately. With LEDGE_BOB_EN: ledgeY over 8 moving ticks = 301,302,303,304,303,302,301,300.

Source files
------------

// File: rtl/ledge_pkg.sv
// Shared types and screen constants for the moving-ledge logic.
package ledge_pkg;

  typedef enum logic [1:0] {
    MOVE_R,
    PAUSE_R,
    MOVE_L,
    PAUSE_L
  } ledge_state_t;

  localparam logic [9:0] LEDGE_HALF_W = 10'd67;
  localparam logic [9:0] LEDGE_HALF_H = 10'd12;
  localparam logic [9:0] SCREEN_W     = 10'd640;
  localparam logic [9:0] SCREEN_H     = 10'd480;

  // Triangle bob profile: 0,1,2,3,4,3,2,1 over the 8 phases.
  function automatic logic [9:0] bob_offset(input logic [2:0] phase);
    logic [3:0] off;
    off = phase[2] ? (4'd8 - {1'b0, phase}) : {1'b0, phase};
    return {6'd0, off};
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector turning a Clk-synchronous frame_clk into a one-Clk tick.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic frame_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) frame_q <= 1'b0;
    else       frame_q <= frame_clk;
  end

  assign tick = frame_clk & ~frame_q;

endmodule

// File: rtl/ledge_mover.sv
// Moving platform: shuttles ledgeX between X_MIN and X_MAX once per frame tick, dwelling at ends.
// Optional vertical bob enabled by defining LEDGE_BOB_EN.
module ledge_mover
  import ledge_pkg::*;
#(
  parameter logic [9:0] X_MIN        = 10'd134,
  parameter logic [9:0] X_MAX        = 10'd506,
  parameter logic [9:0] X_START      = 10'd320,
  parameter logic [9:0] Y_HOME       = 10'd300,
  parameter logic [9:0] STEP         = 10'd2,
  parameter logic [7:0] PAUSE_FRAMES = 8'd60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       enable,
  output logic [9:0] ledgeX,
  output logic [9:0] ledgeY,
  output logic [9:0] ledge_dx,
  output logic       moving_right
);

  ledge_state_t state;
  logic [7:0]   pause_cnt;
  logic         tick;
  logic         hit_right;
  logic         hit_left;
  logic         move_tick;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  // 11-bit compares so neither the sum nor the left bound can wrap.
  assign hit_right = ({1'b0, ledgeX} + {1'b0, STEP}) >= {1'b0, X_MAX};
  assign hit_left  = {1'b0, ledgeX} <= ({1'b0, X_MIN} + {1'b0, STEP});
  assign move_tick = tick & enable & ((state == MOVE_R) | (state == MOVE_L));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= MOVE_R;
      ledgeX       <= X_START;
      ledge_dx     <= '0;
      moving_right <= 1'b1;
      pause_cnt    <= '0;
    end else if (tick) begin
      ledge_dx <= '0;
      if (enable) begin
        unique case (state)
          MOVE_R: begin
            if (hit_right) begin
              ledgeX    <= X_MAX;
              ledge_dx  <= X_MAX - ledgeX;
              pause_cnt <= '0;
              if (PAUSE_FRAMES == 8'd0) begin
                state        <= MOVE_L;
                moving_right <= 1'b0;
              end else begin
                state <= PAUSE_R;
              end
            end else begin
              ledgeX   <= ledgeX + STEP;
              ledge_dx <= STEP;
            end
          end
          PAUSE_R: begin
            if (pause_cnt == PAUSE_FRAMES - 8'd1) begin
              state        <= MOVE_L;
              moving_right <= 1'b0;
            end else begin
              pause_cnt <= pause_cnt + 8'd1;
            end
          end
          MOVE_L: begin
            if (hit_left) begin
              ledgeX    <= X_MIN;
              ledge_dx  <= X_MIN - ledgeX;
              pause_cnt <= '0;
              if (PAUSE_FRAMES == 8'd0) begin
                state        <= MOVE_R;
                moving_right <= 1'b1;
              end else begin
                state <= PAUSE_L;
              end
            end else begin
              ledgeX   <= ledgeX - STEP;
              ledge_dx <= 10'd0 - STEP;
            end
          end
          PAUSE_L: begin
            if (pause_cnt == PAUSE_FRAMES - 8'd1) begin
              state        <= MOVE_R;
              moving_right <= 1'b1;
            end else begin
              pause_cnt <= pause_cnt + 8'd1;
            end
          end
          default: state <= MOVE_R;
        endcase
      end
    end
  end

`ifdef LEDGE_BOB_EN
  logic [2:0] bob_phase;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bob_phase <= '0;
      ledgeY    <= Y_HOME;
    end else if (move_tick) begin
      bob_phase <= bob_phase + 3'd1;
      ledgeY    <= Y_HOME + bob_offset(bob_phase + 3'd1);
    end
  end
`else
  logic unused_move_tick;
  assign unused_move_tick = move_tick;
  assign ledgeY = Y_HOME;
`endif

endmodule

// File: tb/tb_ledge_mover.sv
// Randomized bench for ledge_mover: three parameterisations checked against a per-tick model.
module tb_ledge_mover;

  logic Clk = 1'b0;
  logic Reset;
  logic frame_clk;
  logic enable;

  logic [9:0] lx  [3];
  logic [9:0] ly  [3];
  logic [9:0] ldx [3];
  logic       mr  [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Per-instance parameters: defaults, STEP=4, and PAUSE_FRAMES=0 starting next to X_MAX.
  int p_xmin  [3] = '{134, 134, 134};
  int p_xmax  [3] = '{506, 506, 506};
  int p_step  [3] = '{2, 4, 2};
  int p_pf    [3] = '{60, 60, 0};
  int p_start [3] = '{320, 320, 505};
  int p_yhome = 300;

  int m_x [3];
  int m_y [3];
  int m_dx[3];
  int m_pc[3];
  int m_ph[3];
  bit m_right[3];
  bit m_pause[3];

  always #5 Clk = ~Clk;

  ledge_mover u_dut0 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
    .ledgeX(lx[0]), .ledgeY(ly[0]), .ledge_dx(ldx[0]), .moving_right(mr[0])
  );

  ledge_mover #(.STEP(10'd4)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
    .ledgeX(lx[1]), .ledgeY(ly[1]), .ledge_dx(ldx[1]), .moving_right(mr[1])
  );

  ledge_mover #(.X_START(10'd505), .PAUSE_FRAMES(8'd0)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .enable(enable),
    .ledgeX(lx[2]), .ledgeY(ly[2]), .ledge_dx(ldx[2]), .moving_right(mr[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int bob_y(input int phase);
`ifdef LEDGE_BOB_EN
    return p_yhome + ((phase < 4) ? phase : 8 - phase);
`else
    return p_yhome + 0 * phase;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_x[i]     = p_start[i];
      m_dx[i]    = 0;
      m_pc[i]    = 0;
      m_ph[i]    = 0;
      m_right[i] = 1'b1;
      m_pause[i] = 1'b0;
      m_y[i]     = bob_y(0);
    end
  endtask

  task automatic model_tick(input bit en);
    int nx;
    bit at_end;
    for (int i = 0; i < 3; i++) begin
      m_dx[i] = 0;
      if (!en) continue;
      if (m_pause[i]) begin
        if (m_pc[i] == p_pf[i] - 1) begin
          m_pause[i] = 1'b0;
          m_right[i] = !m_right[i];
        end else begin
          m_pc[i]++;
        end
      end else begin
        if (m_right[i]) begin
          nx     = (m_x[i] + p_step[i] >= p_xmax[i]) ? p_xmax[i] : m_x[i] + p_step[i];
          at_end = (nx == p_xmax[i]);
        end else begin
          nx     = (m_x[i] - p_step[i] <= p_xmin[i]) ? p_xmin[i] : m_x[i] - p_step[i];
          at_end = (nx == p_xmin[i]);
        end
        m_dx[i] = nx - m_x[i];
        m_x[i]  = nx;
        m_ph[i] = (m_ph[i] + 1) % 8;
        m_y[i]  = bob_y(m_ph[i]);
        if (at_end) begin
          m_pc[i] = 0;
          if (p_pf[i] == 0) m_right[i] = !m_right[i];
          else              m_pause[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s x[%0d]", tag, i), {22'd0, lx[i]}, m_x[i]);
      check_eq($sformatf("%s y[%0d]", tag, i), {22'd0, ly[i]}, m_y[i]);
      check_eq($sformatf("%s dx[%0d]", tag, i), {22'd0, ldx[i]}, m_dx[i] & 32'h3FF);
      check_eq($sformatf("%s mr[%0d]", tag, i), {31'd0, mr[i]}, {31'd0, m_right[i]});
    end
  endtask

  // One frame: enable is only meaningful in the tick cycle; it is scrambled in between.
  task automatic do_tick(input bit en, input int max_gap, input string tag);
    @(negedge Clk);
    enable    = en;
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    enable    = 1'($urandom);
    model_tick(en);
    check_all(tag);
    repeat ($urandom_range(max_gap, 0)) @(negedge Clk);
  endtask

  task automatic async_reset(input string tag);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    Reset     = 1'b1;
    frame_clk = 1'b0;
    enable    = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge Clk);
    Reset = 1'b0;

    // Full sweep right, dwell, sweep left, into PAUSE_L on dut0.
    for (int t = 0; t < 344; t++) do_tick(1'b1, 1, "sweep");
    check_eq("sweep end x0", {22'd0, lx[0]}, 134);
    async_reset("reset_pause_l");

    // Frozen ledge holds across ticks.
    for (int t = 0; t < 10; t++) do_tick(1'b0, 2, "frozen");

    for (int t = 0; t < 300; t++) do_tick(($urandom_range(9, 0) < 8), 3, "random");
    async_reset("reset_random");
    for (int t = 0; t < 40; t++) do_tick(1'b1, 2, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
